// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out read-out path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package piso_pkg;

  // Serializer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Level driven on the serial line whenever no data bit is being sent.
  localparam logic IDLE_LEVEL = 1'b1;

  // Width of the bit counter that indexes a WIDTH-bit word.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with enable and zero flag; tracks bits left in a word.
// Latency: load/decrement visible one cycle after the enabling edge.
// Backpressure: none; holds its value whenever en=0 and load=0.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears to 0)
//   load       : load load_val on this edge (wins over en)
//   load_val   : value to load
//   en         : decrement on this edge (saturates at 0)
//   zero       : counter currently reads 0
module piso_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer: one word per load handshake, shifted out at ser_en rate.
// Latency: first bit on ser_out the cycle after the handshake; word period WIDTH+2 with ser_en high.
// Backpressure: load_ready only in IDLE; load_valid outside IDLE is ignored, ser_en=0 freezes the bit.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   load_valid/load_ready : parallel load handshake, load_data captured on valid & ready
//   ser_en                : bit-rate enable, current bit consumed on a SHIFT cycle with ser_en=1
//   ser_out/ser_out_n     : registered complementary serial pair, idle level 1 / 0
//   frame                 : high while data bits are on ser_out
//   done                  : one-cycle pulse after the last bit is consumed
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_out_n,
  output logic             frame,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_out_n_q, ser_out_n_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;

  piso_bit_counter #(
    .W (CW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CW'(WIDTH - 1)),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d  = load_data;
          cnt_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          if (cnt_zero) begin
            state_d = DONE;
          end else begin
            cnt_en  = 1'b1;
            // Move the next bit toward the output end; vacated bit fills with 0.
            shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are computed from the next state/next shift value so that the
    // registered pair presents exactly what the new state requires, with no
    // combinational path from inputs to the pins.
    if (state_d == SHIFT) begin
      ser_out_d = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
    end else begin
      ser_out_d = IDLE_LEVEL;
    end
    ser_out_n_d = ~ser_out_d;
    frame_d     = (state_d == SHIFT);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_out_n_q <= ~IDLE_LEVEL;
      frame_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      ser_out_n_q <= ser_out_n_d;
      frame_q     <= frame_d;
      done_q      <= done_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign ser_out    = ser_out_q;
  assign ser_out_n  = ser_out_n_q;
  assign frame      = frame_q;
  assign done       = done_q;

endmodule
